// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port, with read-return routing
// and a result-window tracker that raises done once every result address has been written.
module mem_port_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2,
  parameter int RES_BASE = 200,
  parameter int RES_CNT = 9,
  localparam int IDW = $clog2(NREQ),
  localparam int CW = $clog2(RES_CNT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata,
  input  logic                    done_clr,
  output logic                    done,
  output logic [CW-1:0]           res_count
);
  logic [IDW-1:0] ptr, gid, idx;
  logic gnt, hit;
  logic [RD_LAT-1:0] pv;
  logic [IDW-1:0] pid [RD_LAT];
  logic [RES_CNT-1:0] bitmap, nxt_map;
  logic [ADDR_W-1:0] off;
  // Scan from the farthest offset down so the closest valid requester after ptr wins.
  always_comb begin
    gid = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) gid = idx;
    end
  end
  assign gnt = |req_valid && !reset;
  assign req_ready = gnt ? NREQ'(1) << gid : '0;
  assign mem_en = gnt;
  assign mem_we = gnt && req_write[gid];
  assign mem_addr = gnt ? req_addr[gid*ADDR_W +: ADDR_W] : '0;
  assign mem_wdata = gnt ? req_wdata[gid*WIDTH +: WIDTH] : '0;
  assign rsp_valid = pv[RD_LAT-1] ? NREQ'(1) << pid[RD_LAT-1] : '0;
  assign rsp_data = mem_rdata;
  assign hit = mem_we && int'(mem_addr) >= RES_BASE && int'(mem_addr) < RES_BASE + RES_CNT;
  assign off = mem_addr - ADDR_W'(RES_BASE);
  // Clear and a same-edge result write combine: the write's bit survives the clear.
  assign nxt_map = (done_clr ? '0 : bitmap) | (hit ? RES_CNT'(1) << off : '0);
  always_comb begin
    res_count = '0;
    for (int k = 0; k < RES_CNT; k++) res_count = res_count + CW'(bitmap[k]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      pv <= '0;
      pid <= '{default: '0};
      bitmap <= '0;
      done <= 1'b0;
    end else begin
      ptr <= gnt ? (gid == IDW'(NREQ - 1) ? '0 : gid + 1'b1) : ptr;
      pv[0] <= gnt && !mem_we;
      pid[0] <= gid;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        pid[k] <= pid[k-1];
      end
      bitmap <= nxt_map;
      done <= &nxt_map;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of arbitration, memory contents, read returns and the result set.
module tb_mem_port_arbiter;
  localparam int N = 4, W = 8, AW = 8, RL = 2, RB = 200, RC = 9, CW = $clog2(RC + 1);
  logic clk = 0, reset = 1, done_clr = 0;
  logic [N-1:0] req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*W-1:0] req_wdata = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [W-1:0] rsp_data, mem_wdata, mem_rdata;
  logic mem_en, mem_we, done;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] res_count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.NREQ(N), .WIDTH(W), .ADDR_W(AW), .RD_LAT(RL), .RES_BASE(RB), .RES_CNT(RC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .done_clr(done_clr), .done(done), .res_count(res_count));

  // Memory environment: synchronous RAM with an RL-stage read pipeline.
  logic [W-1:0] ram [256] = '{default: '0};
  logic [W-1:0] rp [RL];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    rp[0] <= ram[mem_addr];
    for (int i = 1; i < RL; i++) rp[i] <= rp[i-1];
  end
  assign mem_rdata = rp[RL-1];

  // Reference model state
  int e = 0, last_g = -1, m_ptr = 0;
  bit ev [16];
  int eid [16];
  logic [W-1:0] ed [16];
  logic [W-1:0] m_mem [256] = '{default: '0};
  bit m_set [RC];
  logic [N-1:0] s_ready, s_rsp;
  logic [W-1:0] s_data;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, x, $time);
    end
  endfunction

  function automatic bit vbit(logic [N-1:0] v, int j);
    logic [N-1:0] t;
    t = v >> j;
    return t[0];
  endfunction

  task automatic setreq(int i, bit w, int a, int d);
    logic [N-1:0] m;
    logic [N*AW-1:0] am;
    logic [N*W-1:0] dm;
    m = N'(1) << i;
    am = {AW{1'b1}};
    am = am << (i * AW);
    dm = {W{1'b1}};
    dm = dm << (i * W);
    req_valid |= m;
    req_write = w ? (req_write | m) : (req_write & ~m);
    req_addr = (req_addr & ~am) | ((N*AW)'(a & 255) << (i * AW));
    req_wdata = (req_wdata & ~dm) | ((N*W)'(d & 255) << (i * W));
  endtask

  // One clock: compare at negedge, advance the model at posedge, return 1 time unit later.
  task automatic tick();
    int g, cnt;
    bit wr;
    logic [AW-1:0] a;
    logic [W-1:0] d;
    @(negedge clk);
    if (reset) begin
      m_ptr = 0;
      foreach (ev[i]) ev[i] = 0;
      foreach (m_set[i]) m_set[i] = 0;
    end
    g = -1;
    a = '0;
    d = '0;
    if (!reset)
      for (int k = 0; k < N; k++) if (g < 0 && vbit(req_valid, (m_ptr + k) % N)) g = (m_ptr + k) % N;
    if (g >= 0) begin
      a = AW'(req_addr >> (g * AW));
      d = W'(req_wdata >> (g * W));
    end
    wr = g >= 0 && vbit(req_write, g);
    cnt = 0;
    foreach (m_set[i]) cnt += int'(m_set[i]);
    s_ready = req_ready;
    s_rsp = rsp_valid;
    s_data = rsp_data;
    chk("req_ready", req_ready, g < 0 ? 0 : 1 << g);
    chk("mem_en", mem_en, g >= 0);
    chk("mem_we", mem_we, wr);
    if (g >= 0) chk("mem_addr", mem_addr, a);
    if (wr) chk("mem_wdata", mem_wdata, d);
    chk("rsp_valid", rsp_valid, ev[e%16] ? 1 << eid[e%16] : 0);
    if (ev[e%16]) chk("rsp_data", rsp_data, ed[e%16]);
    chk("res_count", res_count, cnt);
    chk("done", done, cnt == RC);
    ev[e%16] = 0;
    @(posedge clk);
    e++;
    last_g = g;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (wr) m_mem[a] = d;
      else begin
        ev[(e+RL-1)%16] = 1;
        eid[(e+RL-1)%16] = g;
        ed[(e+RL-1)%16] = m_mem[a];
      end
    end
    if (!reset && done_clr) foreach (m_set[i]) m_set[i] = 0;
    if (wr && int'(a) >= RB && int'(a) < RB + RC) m_set[int'(a) - RB] = 1;
    #1;
  endtask

  task automatic idle(int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    req_valid = '1;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_done", done, 0);
    chk("rst_count", res_count, 0);
    req_valid = '0;
    reset = 0;
    tick();
    // All requesters valid: strict rotation
    for (int i = 0; i < N; i++) setreq(i, 0, 20 + i, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t1_grant", s_ready, 4'b0001 << (c % 4));
    end
    idle(RL + 1);
    // Lone requester 2, then from ptr=3
    setreq(2, 0, 30, 0);
    tick();
    chk("t2_grant_a", s_ready, 4'b0100);
    tick();
    chk("t2_grant_b", s_ready, 4'b0100);
    for (int i = 0; i < N; i++) setreq(i, 0, 31, 0);
    tick();
    chk("t2_ptr3", s_ready, 4'b1000);
    idle(RL + 1);
    // Write then read-back of the same address
    setreq(1, 1, 10, 8'h5A);
    tick();
    chk("t3_wgrant", s_ready, 4'b0010);
    req_valid = '0;
    setreq(0, 0, 10, 0);
    tick();
    chk("t3_rgrant", s_ready, 4'b0001);
    req_valid = '0;
    for (int t = 1; t <= RL; t++) begin
      tick();
      chk("t3_rsp_valid", s_rsp, t == RL ? 4'b0001 : 4'b0000);
      if (t == RL) chk("t3_rsp_data", s_data, 8'h5A);
    end
    // Fill the result window, 208 written twice
    for (int i = 0; i < 10; i++) begin
      req_valid = '0;
      setreq(3, 1, i < 9 ? RB + i : RB + 8, 16 + i);
      tick();
      chk("t4_count", res_count, i < 9 ? i + 1 : 9);
      chk("t4_done", done, i >= 8);
    end
    // Clear with a simultaneous result write, then out-of-window writes
    done_clr = 1;
    setreq(3, 1, 203, 1);
    tick();
    done_clr = 0;
    chk("t5_count", res_count, 1);
    chk("t5_done", done, 0);
    setreq(3, 1, 199, 2);
    tick();
    chk("t5_lo", res_count, 1);
    setreq(3, 1, 209, 3);
    tick();
    chk("t5_hi", res_count, 1);
    // Reset with two reads in flight
    req_valid = '0;
    setreq(0, 0, 10, 0);
    tick();
    req_valid = '0;
    setreq(1, 0, 203, 0);
    tick();
    setreq(2, 0, 5, 0);
    #2 reset = 1;
    #1;
    chk("t6_ready", req_ready, 0);
    chk("t6_mem_en", mem_en, 0);
    chk("t6_rsp", rsp_valid, 0);
    chk("t6_done", done, 0);
    chk("t6_count", res_count, 0);
    tick();
    reset = 0;
    req_valid = '0;
    for (int t = 0; t < RL + 2; t++) begin
      tick();
      chk("t6_no_rsp", s_rsp, 0);
    end
    // Randomized traffic with one mid-run reset pulse
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) reset = 1;
      if (c == 1503) reset = 0;
      done_clr = $urandom_range(0, 63) == 0;
      for (int i = 0; i < N; i++)
        if (!(vbit(req_valid, i) && last_g != i)) begin
          if ($urandom_range(0, 2) != 0)
            setreq(i, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(196, 212)),
                   int'($urandom_range(0, 255)));
          else req_valid &= ~(N'(1) << i);
        end
      tick();
    end
    done_clr = 0;
    idle(RL + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
